arilla_mtimer: RTL and testbench
================================

ARILLA_MTIMER -- requirements
Module: arilla_mtimer

Interface
REQ-001 Parameter BaseAddress, default 32'h0000_4000; byte address of register block, 32-byte aligned.
REQ-002 Parameter ByteAddressWidth, default 32; bus byte-address width.
REQ-003 Parameter PrescaleWidth, default 8; width of the tick prescaler.
REQ-004 Clock and reset are decided: one clock, reset asynchronous and active-high.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 data_ctp  in  32  write data, controller to peripheral.
REQ-008 data_ptc  out  32  read data, peripheral to controller; 0 when not selected (wired-OR bus).
REQ-009 address  in  ByteAddressWidth-2  word address.
REQ-010 byte_enable  in  4  per-byte write enable.
REQ-011 read  in  1  read strobe, single cycle.
REQ-012 write  in  1  write strobe, single cycle.
REQ-013 intercept  in  1  another agent owns this access; block ignores it.
REQ-014 hit  out  1  block decodes the current access.
REQ-015 halt  in  1  debug halt; freezes counting.
REQ-016 irq  out  1  machine timer interrupt, registered.

Function
REQ-017 Register map (word offset from BaseAddress): 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL, 5-7 reserved.
REQ-018 CTRL: bit0 EN, bits[8+PrescaleWidth-1:8] PRESCALE; other bits read 0, writes ignored.
REQ-019 sel = (read|write) & ~intercept & address[upper] == BaseAddress word-address upper bits; hit = sel, combinational.
REQ-020 Reserved offsets: hit asserted, reads return 0, writes ignored.
REQ-021 Read: data_ptc combinational from addressed register in same cycle when sel & read; otherwise 0.
REQ-022 Reading MTIME_LO latches mtime[63:32] into a shadow at that clock edge; a subsequent MTIME_HI read returns the shadow (atomic 64-bit read).
REQ-023 MTIME_HI read without a preceding MTIME_LO read returns the shadow's current value (reset value 0).
REQ-024 Write: on sel & write edge, each byte with byte_enable set updates; other bytes hold.
REQ-025 Read and write strobes both asserted: write performed, read data reflects pre-write value.
REQ-026 Prescaler: counter pcnt increments each cycle when EN & ~halt; when pcnt == PRESCALE, pcnt <= 0 and tick = 1 for that cycle.
REQ-027 PRESCALE = 0: tick every enabled cycle.
REQ-028 On tick, mtime <= mtime + 1, modulo 2^64 (all-ones wraps to 0, no flag).
REQ-029 Write to MTIME_LO/HI in a tick cycle: written bytes take write data, unwritten bytes of that word keep pre-increment value; other word of mtime unchanged (no carry applied that cycle).
REQ-030 Write to CTRL clearing EN: pcnt holds its value; counting resumes from it when EN set.
REQ-031 Write to CTRL.PRESCALE resets pcnt to 0 the same edge.
REQ-032 halt high: pcnt and mtime hold; bus access unaffected.
REQ-033 irq <= (mtime >= mtimecmp), unsigned 64-bit, evaluated on register values each cycle; one-cycle latency from compare state to irq.
REQ-034 intercept high: hit = 0, data_ptc = 0, no register update, no shadow latch.

Reset
REQ-035 On rst: mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, CTRL = 0 (EN=0, PRESCALE=0), pcnt = 0, shadow = 0, irq = 0.
REQ-036 Reset asserted mid-access: access discarded; combinational hit/data_ptc still follow REQ-019/021 with reset register values.
REQ-037 First tick after reset release requires an explicit CTRL.EN write.

Verification
REQ-038 Write CTRL=0x0000_0001, idle 10 cycles -> MTIME_LO reads 10 (+/- strobe cycle per REQ-025), MTIME_HI reads 0.
REQ-039 Set mtime=0x0000_0000_FFFF_FFFE, PRESCALE=0, EN=1; read LO after carry -> LO/HI pair consistent (HI=1 once LO < 0xFFFF_FFFE), no torn read via shadow.
REQ-040 mtimecmp=5, EN=1 from mtime=0 -> irq rises exactly one cycle after mtime reaches 5; write mtimecmp_hi=0xFFFF_FFFF -> irq falls next cycle.
REQ-041 Write MTIMECMP_LO with byte_enable=4'b0010, data 0xAABBCCDD from all-ones -> reads 0xFFFFCCFF.
REQ-042 PRESCALE=3, EN=1, halt pulsed 4 cycles mid-run -> mtime increments every 4 enabled cycles; no increment during halt.
REQ-043 Access to offset 2 with intercept=1 and write=1 -> hit=0, data_ptc=0, mtimecmp unchanged; address outside block -> hit=0.

Source files
------------

// File: rtl/arilla_mtimer.sv
// Purpose: memory-mapped 64-bit machine timer (mtime/mtimecmp) with prescaler, atomic HI read shadow and irq.
// Latency: read data is combinational in the strobe cycle; writes land on the strobe edge; irq lags compare by one cycle.
// Backpressure: none; every decoded access completes in one cycle, and intercepted accesses are ignored.
module arilla_mtimer #(
    parameter int ByteAddressWidth = 32,
    parameter logic [ByteAddressWidth-1:0] BaseAddress = 32'h0000_4000,
    parameter int PrescaleWidth = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 data_ctp,
    output logic [31:0]                 data_ptc,
    input  logic [ByteAddressWidth-3:0] address,
    input  logic [3:0]                  byte_enable,
    input  logic                        read,
    input  logic                        write,
    input  logic                        intercept,
    output logic                        hit,
    input  logic                        halt,
    output logic                        irq
);

    localparam int WordAw = ByteAddressWidth - 2;
    // Bit positions of the PRESCALE field inside the CTRL word.
    localparam logic [31:0] PrescaleMask = ((32'h1 << PrescaleWidth) - 32'h1) << 8;

    localparam logic [2:0] OffMtimeLo = 3'd0;
    localparam logic [2:0] OffMtimeHi = 3'd1;
    localparam logic [2:0] OffCmpLo   = 3'd2;
    localparam logic [2:0] OffCmpHi   = 3'd3;
    localparam logic [2:0] OffCtrl    = 3'd4;

    logic [63:0]              mtime;
    logic [63:0]              mtimecmp;
    logic [31:0]              shadow;
    logic                     ctrl_en;
    logic [PrescaleWidth-1:0] ctrl_prescale;
    logic [PrescaleWidth-1:0] pcnt;

    logic        sel;
    logic [2:0]  offset;
    logic        wr_sel;
    logic [31:0] be_mask;
    logic [31:0] ctrl_word;
    logic [31:0] rdata;
    logic        prescale_touched;
    logic        count_en;
    logic        tick;

    // Replace only the enabled bytes of a register word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        end
        return res;
    endfunction

    assign offset   = address[2:0];
    assign sel      = (read | write) & ~intercept
                      & (address[WordAw-1:3] == BaseAddress[ByteAddressWidth-1:5]);
    assign hit      = sel;
    assign wr_sel   = sel & write;
    assign be_mask  = {{8{byte_enable[3]}}, {8{byte_enable[2]}},
                       {8{byte_enable[1]}}, {8{byte_enable[0]}}};
    assign prescale_touched = |(be_mask & PrescaleMask);
    assign count_en = ctrl_en & ~halt;
    assign tick     = count_en & (pcnt == ctrl_prescale);
    assign data_ptc = rdata;

    // Assemble the CTRL word; undefined bits read as zero.
    always_comb begin
        ctrl_word                     = '0;
        ctrl_word[0]                  = ctrl_en;
        ctrl_word[8 +: PrescaleWidth] = ctrl_prescale;
    end

    // Read mux: drives zero unless this block owns a read, so it can be OR-ed onto the bus.
    always_comb begin
        rdata = '0;
        if (sel && read) begin
            case (offset)
                OffMtimeLo: rdata = mtime[31:0];
                OffMtimeHi: rdata = shadow;
                OffCmpLo:   rdata = mtimecmp[31:0];
                OffCmpHi:   rdata = mtimecmp[63:32];
                OffCtrl:    rdata = ctrl_word;
                default:    rdata = '0;
            endcase
        end
    end

    // CTRL register: EN and PRESCALE follow their own byte enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en       <= 1'b0;
            ctrl_prescale <= '0;
        end else if (wr_sel && offset == OffCtrl) begin
            if (byte_enable[0]) ctrl_en <= data_ctp[0];
            ctrl_prescale <= (data_ctp[8 +: PrescaleWidth] & be_mask[8 +: PrescaleWidth])
                           | (ctrl_prescale & ~be_mask[8 +: PrescaleWidth]);
        end
    end

    // Prescaler: restarts when PRESCALE is rewritten, otherwise counts while enabled and not halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (wr_sel && offset == OffCtrl && prescale_touched) begin
            pcnt <= '0;
        end else if (count_en) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
        end
    end

    // mtime: a bus write to either word wins over the tick, and no carry crosses words that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= '0;
        end else if (wr_sel && offset == OffMtimeLo) begin
            mtime[31:0] <= merge_bytes(mtime[31:0], data_ctp, byte_enable);
        end else if (wr_sel && offset == OffMtimeHi) begin
            mtime[63:32] <= merge_bytes(mtime[63:32], data_ctp, byte_enable);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp: byte-granular writes to either word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimecmp <= '1;
        end else if (wr_sel && offset == OffCmpLo) begin
            mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], data_ctp, byte_enable);
        end else if (wr_sel && offset == OffCmpHi) begin
            mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], data_ctp, byte_enable);
        end
    end

    // Shadow: capture the upper word whenever the lower word is read, giving a tear-free 64-bit read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (sel && read && offset == OffMtimeLo) begin
            shadow <= mtime[63:32];
        end
    end

    // Interrupt: registered unsigned compare of the current register values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_arilla_mtimer.sv
module tb_arilla_mtimer;

    localparam logic [29:0] BASE_W = 30'h0000_1000;
    localparam logic [2:0]  O_MLO  = 3'd0;
    localparam logic [2:0]  O_MHI  = 3'd1;
    localparam logic [2:0]  O_CLO  = 3'd2;
    localparam logic [2:0]  O_CHI  = 3'd3;
    localparam logic [2:0]  O_CTRL = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_ctp;
    logic [31:0] data_ptc;
    logic [29:0] address;
    logic [3:0]  byte_enable;
    logic        read;
    logic        write;
    logic        intercept;
    logic        hit;
    logic        halt;
    logic        irq;

    int errors = 0;
    int checks = 0;

    arilla_mtimer dut (
        .clk         (clk),
        .rst         (rst),
        .data_ctp    (data_ctp),
        .data_ptc    (data_ptc),
        .address     (address),
        .byte_enable (byte_enable),
        .read        (read),
        .write       (write),
        .intercept   (intercept),
        .hit         (hit),
        .halt        (halt),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All bus tasks start at a falling edge and consume exactly one clock cycle.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] be);
        address = BASE_W + 30'(off); data_ctp = d; byte_enable = be; write = 1'b1;
        @(negedge clk);
        write = 1'b0; byte_enable = 4'b0; data_ctp = '0;
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] d, output logic h);
        address = BASE_W + 30'(off); read = 1'b1;
        #1 d = data_ptc; h = hit;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic rd_chk(input logic [2:0] off, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        logic        h;
        rd(off, d, h);
        check(tag, d, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        h;
        rst = 1'b1; data_ctp = '0; address = BASE_W; byte_enable = '0;
        read = 1'b0; write = 1'b0; intercept = 1'b0; halt = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values and bus behaviour while held in reset.
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_idle_hit", {31'b0, hit}, 32'h0);
        check("rst_idle_data", data_ptc, 32'h0);
        rd(O_CLO, d, h);
        check("rst_rd_hit", {31'b0, h}, 32'h1);
        check("rst_rd_cmp_lo", d, 32'hFFFF_FFFF);
        wr(O_CLO, 32'h0, 4'hF);
        rst = 1'b0;
        idle(5);
        rd_chk(O_CLO, 32'hFFFF_FFFF, "rst_wr_discarded");
        rd_chk(O_CHI, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd_chk(O_CTRL, 32'h0, "rst_ctrl");
        rd_chk(O_MLO, 32'h0, "no_tick_without_en");
        rd(3'd5, d, h);
        check("reserved_hit", {31'b0, h}, 32'h1);
        check("reserved_data", d, 32'h0);

        // Ten enabled idle cycles at PRESCALE=0.
        wr(O_CTRL, 32'h1, 4'hF);
        idle(10);
        rd_chk(O_MLO, 32'd10, "count10_lo");
        rd_chk(O_MHI, 32'd0, "count10_hi");
        wr(O_CTRL, 32'h0, 4'hF);
        rd_chk(O_MLO, 32'd13, "count_stopped");

        // Carry across words; HI read after carry still returns the pre-carry shadow.
        wr(O_MHI, 32'h0, 4'hF);
        wr(O_MLO, 32'hFFFF_FFFE, 4'hF);
        wr(O_CTRL, 32'h1, 4'hF);
        idle(1);
        rd_chk(O_MLO, 32'hFFFF_FFFF, "carry_lo_pre");
        rd_chk(O_MHI, 32'h0, "carry_hi_shadow_old");
        rd_chk(O_MLO, 32'h1, "carry_lo_post");
        rd_chk(O_MHI, 32'h1, "carry_hi_post");
        wr(O_CTRL, 32'h0, 4'hF);
        rd_chk(O_MLO, 32'h4, "carry_lo_final");

        // Partial write to MTIME_LO in a tick cycle: no increment, no carry.
        wr(O_MLO, 32'hFFFF_FFFF, 4'hF);
        wr(O_MHI, 32'h0, 4'hF);
        wr(O_CTRL, 32'h1, 4'hF);
        wr(O_MLO, 32'h0000_0022, 4'b0001);
        wr(O_CTRL, 32'h0, 4'hF);
        rd_chk(O_MLO, 32'hFFFF_FF23, "tickwr_lo");
        rd_chk(O_MHI, 32'h0, "tickwr_hi");

        // Compare and interrupt timing.
        wr(O_MLO, 32'h0, 4'hF);
        wr(O_MHI, 32'h0, 4'hF);
        wr(O_CHI, 32'h0, 4'hF);
        wr(O_CLO, 32'd5, 4'hF);
        wr(O_CTRL, 32'h1, 4'hF);
        idle(4);
        check("irq_at_mtime4", {31'b0, irq}, 32'h0);
        idle(1);
        check("irq_at_mtime5", {31'b0, irq}, 32'h0);
        idle(1);
        check("irq_rise", {31'b0, irq}, 32'h1);
        wr(O_CHI, 32'hFFFF_FFFF, 4'hF);
        idle(1);
        check("irq_fall", {31'b0, irq}, 32'h0);
        wr(O_CTRL, 32'h0, 4'hF);

        // Byte-enable merge on MTIMECMP_LO.
        wr(O_CLO, 32'hFFFF_FFFF, 4'hF);
        wr(O_CLO, 32'hAABB_CCDD, 4'b0010);
        rd_chk(O_CLO, 32'hFFFF_CCFF, "cmp_be_merge");

        // PRESCALE=3 with a four-cycle halt mid-count.
        wr(O_MLO, 32'h0, 4'hF);
        wr(O_MHI, 32'h0, 4'hF);
        wr(O_CTRL, 32'h0000_0301, 4'hF);
        rd_chk(O_CTRL, 32'h0000_0301, "ctrl_readback");
        idle(3);
        rd_chk(O_MLO, 32'h1, "ps_first_tick");
        idle(1);
        halt = 1'b1;
        idle(2);
        rd_chk(O_MLO, 32'h1, "ps_halt_hold");
        idle(1);
        halt = 1'b0;
        idle(1);
        rd_chk(O_MLO, 32'h1, "ps_resume_pre");
        rd_chk(O_MLO, 32'h2, "ps_resume_tick");

        // Clearing EN keeps pcnt; re-enabling continues from it.
        wr(O_CTRL, 32'h0, 4'b0001);
        idle(3);
        wr(O_CTRL, 32'h1, 4'b0001);
        idle(1);
        rd_chk(O_MLO, 32'h2, "en_resume_pre");
        rd_chk(O_MLO, 32'h3, "en_resume_tick");

        // Rewriting PRESCALE restarts the prescaler.
        wr(O_CTRL, 32'h0000_0300, 4'b0010);
        idle(2);
        rd_chk(O_MLO, 32'h3, "ps_restart_pre");
        rd_chk(O_MLO, 32'h3, "ps_restart_edge");
        rd_chk(O_MLO, 32'h4, "ps_restart_tick");
        wr(O_CTRL, 32'h0, 4'hF);

        // Simultaneous read and write returns the old value.
        address = BASE_W + 30'(O_CLO); data_ctp = 32'h1234_5678; byte_enable = 4'hF;
        read = 1'b1; write = 1'b1;
        #1 check("rw_old_value", data_ptc, 32'hFFFF_CCFF);
        @(negedge clk);
        read = 1'b0; write = 1'b0; byte_enable = '0; data_ctp = '0;
        rd_chk(O_CLO, 32'h1234_5678, "rw_new_value");

        // Intercepted access is invisible and has no effect.
        address = BASE_W + 30'(O_CLO); data_ctp = 32'h0; byte_enable = 4'hF;
        read = 1'b1; write = 1'b1; intercept = 1'b1;
        #1 check("icpt_hit", {31'b0, hit}, 32'h0);
        check("icpt_data", data_ptc, 32'h0);
        @(negedge clk);
        read = 1'b0; write = 1'b0; intercept = 1'b0; byte_enable = '0;
        rd_chk(O_CLO, 32'h1234_5678, "icpt_no_update");

        // Addresses just outside the block.
        address = BASE_W + 30'd8; read = 1'b1;
        #1 check("outside_above_hit", {31'b0, hit}, 32'h0);
        check("outside_above_data", data_ptc, 32'h0);
        @(negedge clk);
        address = BASE_W - 30'd1;
        #1 check("outside_below_hit", {31'b0, hit}, 32'h0);
        @(negedge clk);
        read = 1'b0;

        // 64-bit wrap from all ones.
        wr(O_MLO, 32'hFFFF_FFFF, 4'hF);
        wr(O_MHI, 32'hFFFF_FFFF, 4'hF);
        wr(O_CTRL, 32'h1, 4'hF);
        rd_chk(O_MLO, 32'hFFFF_FFFF, "wrap_pre");
        rd_chk(O_MLO, 32'h0, "wrap_lo");
        rd_chk(O_MHI, 32'h0, "wrap_hi");
        wr(O_CTRL, 32'h0, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
